// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcodes, FSM state encoding and iteration-count helper
// shared by the sequential ALU and its digit adder.
package seq_alu_pkg;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_BCD  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Number of RUN iterations an opcode needs for a given operand width:
  // one per BCD digit, one per multiplier bit, a single step otherwise.
  function automatic int op_iters(input logic [1:0] op, input int width);
    int n;
    case (op)
      OP_BCD:  n = width / 4;
      OP_MUL:  n = width;
      default: n = 1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq_alu_bcd_digit_adder.sv
// bcd_digit_adder: one decimal digit of a BCD addition with carry in/out.
// Digits above 9 are still summed by the same rule but flagged invalid.
module bcd_digit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout,
  output logic       invalid
);

  logic [4:0] sum;

  // Binary digit sum, then decimal correction when it exceeds nine
  always_comb begin
    sum     = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    invalid = (a > 4'd9) || (b > 4'd9);
    if (sum > 5'd9) begin
      digit = sum[3:0] + 4'd6;
      cout  = 1'b1;
    end else begin
      digit = sum[3:0];
      cout  = 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a start/busy/done handshake. Operands are
// latched on accept; pass and add finish in one step, BCD add walks one
// digit per cycle, multiply does one shift-add step per multiplier bit.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           S,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   Y,
  output logic                 bcd_err
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
    $error("seq_alu: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t           state;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [W2-1:0]    acc;
  logic             carry_r;
  logic             err_r;
  logic [CW-1:0]    cnt;

  logic [3:0]       dig;
  logic             dig_cout;
  logic             dig_bad;
  logic [WIDTH+3:0] bcd_cat;
  logic [WIDTH-1:0] bcd_next;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  logic             last;

  // The low digit of the shifting operand registers is always the one in work
  bcd_digit_adder u_digit (
    .a       (a_r[3:0]),
    .b       (b_r[3:0]),
    .cin     (carry_r),
    .digit   (dig),
    .cout    (dig_cout),
    .invalid (dig_bad)
  );

  // Next-step values for every datapath, selected by the FSM below
  always_comb begin
    bcd_cat  = {dig, acc[WIDTH-1:0]};
    bcd_next = bcd_cat[WIDTH+3:4];
    add_sum  = {1'b0, a_r} + {1'b0, b_r};
    mul_sum  = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, a_r} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    last     = (cnt == CW'(op_iters(op_r, WIDTH) - 1));
  end

  // Handshake FSM with registered result, flags and iteration state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      Y       <= '0;
      bcd_err <= 1'b0;
      op_r    <= OP_PASS;
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      carry_r <= 1'b0;
      err_r   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r    <= S;
            a_r     <= A;
            b_r     <= B;
            acc     <= (S == OP_MUL) ? W2'(B) : '0;
            carry_r <= 1'b0;
            err_r   <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (last) begin
            case (op_r)
              OP_PASS: Y <= {a_r, b_r};
              OP_ADD:  Y <= W2'(add_sum);
              OP_BCD:  Y <= W2'({dig_cout, bcd_next});
              default: Y <= mul_next;
            endcase
            bcd_err <= (op_r == OP_BCD) ? (err_r | dig_bad) : 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
            case (op_r)
              OP_BCD: begin
                acc[WIDTH-1:0] <= bcd_next;
                a_r            <= a_r >> 4;
                b_r            <= b_r >> 4;
                carry_r        <= dig_cout;
                err_r          <= err_r | dig_bad;
              end
              OP_MUL:  acc <= mul_next;
              default: ;
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: drives WIDTH=4, 8 and 16 instances of seq_alu. The WIDTH=8
// instance is shadowed every cycle by a latency/arithmetic reference model;
// all three also get directed operations with hand-computed results.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start4 = 1'b0, start8 = 1'b0, start16 = 1'b0;
  logic [1:0]  s = 2'b00;
  logic [15:0] a = '0, b = '0;

  logic        busy4, done4, err4;
  logic [7:0]  y4;
  logic        busy8, done8, err8;
  logic [15:0] y8;
  logic        busy16, done16, err16;
  logic [31:0] y16;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .S(s), .A(a[3:0]), .B(b[3:0]),
    .busy(busy4), .done(done4), .Y(y4), .bcd_err(err4));

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .S(s), .A(a[7:0]), .B(b[7:0]),
    .busy(busy8), .done(done8), .Y(y8), .bcd_err(err8));

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .S(s), .A(a), .B(b),
    .busy(busy16), .done(done16), .Y(y16), .bcd_err(err16));

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of an operation straight from the arithmetic rules; bit 64 is bcd_err
  function automatic logic [64:0] refResult(input logic [1:0] op, input logic [63:0] av,
                                            input logic [63:0] bv, input int w);
    logic [63:0] y;
    logic        err;
    int          c, da, db, sum;
    y = '0;
    err = 1'b0;
    case (op)
      2'b00: y = (av << w) | bv;
      2'b01: y = av + bv;
      2'b11: y = av * bv;
      default: begin
        c = 0;
        for (int i = 0; i < w / 4; i++) begin
          da = int'((av >> (4 * i)) & 64'hF);
          db = int'((bv >> (4 * i)) & 64'hF);
          sum = da + db + c;
          if (sum > 9) begin
            y |= 64'((sum + 6) % 16) << (4 * i);
            c = 1;
          end else begin
            y |= 64'(sum) << (4 * i);
            c = 0;
          end
          if (da > 9 || db > 9) err = 1'b1;
        end
        y |= 64'(c) << w;
      end
    endcase
    return {err, y};
  endfunction

  function automatic int refLatency(input logic [1:0] op, input int w);
    if (op == 2'b11) return w;
    if (op == 2'b10) return w / 4;
    return 1;
  endfunction

  // Reference model for the WIDTH=8 instance: accepts when idle, counts down
  // the latency, then publishes the precomputed result for one done cycle
  logic        m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [15:0] m_y = '0;
  int          m_left = 0;
  logic [64:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_y = '0; m_left = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_y    = m_pend[15:0];
        m_err  = m_pend[64];
      end
    end else begin
      m_done = 1'b0;
      if (start8) begin
        m_busy = 1'b1;
        m_left = refLatency(s, 8);
        m_pend = refResult(s, 64'(a[7:0]), 64'(b[7:0]), 8);
      end
    end
  end

  // Compare the WIDTH=8 outputs with the model on every falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cmp_busy8", 64'(busy8), 64'(m_busy));
      checkOutput("cmp_done8", 64'(done8), 64'(m_done));
      checkOutput("cmp_y8",    64'(y8),    64'(m_y));
      checkOutput("cmp_err8",  64'(err8),  64'(m_err));
    end
  end

  task automatic setStart(input int sel, input logic v);
    case (sel)
      4:       start4 = v;
      8:       start8 = v;
      default: start16 = v;
    endcase
  endtask

  function automatic logic getDone(input int sel);
    return (sel == 4) ? done4 : (sel == 8) ? done8 : done16;
  endfunction

  function automatic logic getBusy(input int sel);
    return (sel == 4) ? busy4 : (sel == 8) ? busy8 : busy16;
  endfunction

  function automatic logic getErr(input int sel);
    return (sel == 4) ? err4 : (sel == 8) ? err8 : err16;
  endfunction

  function automatic logic [63:0] getY(input int sel);
    return (sel == 4) ? 64'(y4) : (sel == 8) ? 64'(y8) : 64'(y16);
  endfunction

  // One operation: accept, scramble the operands, then time busy and done
  task automatic applyStimulus(input int sel, input logic [1:0] op, input logic [15:0] av,
                               input logic [15:0] bv, input logic [63:0] exp_y,
                               input logic exp_err, input int exp_lat, input string name);
    int  lat, nbusy;
    bit  seen;
    @(negedge clk);
    s = op; a = av; b = bv;
    setStart(sel, 1'b1);
    @(posedge clk); #1;
    setStart(sel, 1'b0);
    a = 16'($urandom); b = 16'($urandom); s = 2'($urandom);
    nbusy = getBusy(sel) ? 1 : 0;
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (getDone(sel)) seen = 1'b1;
      else if (getBusy(sel)) nbusy++;
    end
    checkOutput({name, "_done_seen"}, 64'(seen), 64'd1);
    checkOutput({name, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({name, "_busy_cycles"}, 64'(nbusy), 64'(exp_lat));
    checkOutput({name, "_y"}, getY(sel), exp_y);
    checkOutput({name, "_err"}, 64'(getErr(sel)), 64'(exp_err));
  endtask

  // Multiply, then an add requested during the done cycle of the multiply
  task automatic backToBack(input int sel, input logic [15:0] a1, input logic [15:0] b1,
                            input logic [63:0] y1, input logic [15:0] a2,
                            input logic [15:0] b2, input logic [63:0] y2, input string name);
    bit seen;
    @(negedge clk);
    s = 2'b11; a = a1; b = b1;
    setStart(sel, 1'b1);
    @(posedge clk); #1;
    setStart(sel, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (getDone(sel)) seen = 1'b1;
    end
    checkOutput({name, "_first_done"}, 64'(seen), 64'd1);
    checkOutput({name, "_first_y"}, getY(sel), y1);
    s = 2'b01; a = a2; b = b2;
    setStart(sel, 1'b1);
    @(posedge clk); #1;
    setStart(sel, 1'b0);
    checkOutput({name, "_accept_busy"}, 64'(getBusy(sel)), 64'd1);
    checkOutput({name, "_accept_done"}, 64'(getDone(sel)), 64'd0);
    checkOutput({name, "_y_held"}, getY(sel), y1);
    @(posedge clk); #1;
    checkOutput({name, "_second_done"}, 64'(getDone(sel)), 64'd1);
    checkOutput({name, "_second_y"}, getY(sel), y2);
  endtask

  initial begin
    int ndone;
    logic [63:0] y_at_done;

    repeat (2) @(negedge clk);
    checkOutput("reset_y8", 64'(y8), 64'd0);
    checkOutput("reset_busy8", 64'(busy8), 64'd0);
    checkOutput("reset_done8", 64'(done8), 64'd0);
    checkOutput("reset_err8", 64'(err8), 64'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    checkOutput("model_bcd_59_48", refResult(2'b10, 64'h59, 64'h48, 8), 65'h107);
    checkOutput("model_mul_ff_ff", refResult(2'b11, 64'hFF, 64'hFF, 8), 65'hFE01);

    applyStimulus(8, 2'b01, 16'hC8, 16'h64, 64'h012C, 1'b0, 1, "add_c8_64");
    applyStimulus(8, 2'b00, 16'h12, 16'h34, 64'h1234, 1'b0, 1, "pass_12_34");
    applyStimulus(8, 2'b10, 16'h59, 16'h48, 64'h0107, 1'b0, 2, "bcd_59_48");
    applyStimulus(8, 2'b10, 16'h99, 16'h01, 64'h0100, 1'b0, 2, "bcd_99_01");
    applyStimulus(8, 2'b10, 16'h5A, 16'h01, 64'h0061, 1'b1, 2, "bcd_5a_01");
    applyStimulus(8, 2'b01, 16'h01, 16'h02, 64'h0003, 1'b0, 1, "add_clears_err");
    applyStimulus(8, 2'b11, 16'hFF, 16'hFF, 64'hFE01, 1'b0, 8, "mul_ff_ff");
    applyStimulus(8, 2'b11, 16'h00, 16'hAB, 64'h0000, 1'b0, 8, "mul_00_ab");

    // Start pulse during the third multiply cycle must be dropped
    @(negedge clk);
    s = 2'b11; a = 16'hFF; b = 16'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    s = 2'b01; a = 16'h01; b = 16'h01; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    ndone = 0;
    y_at_done = '0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        ndone++;
        y_at_done = 64'(y8);
      end
    end
    checkOutput("busy_start_done_count", 64'(ndone), 64'd1);
    checkOutput("busy_start_y", y_at_done, 64'hFE01);

    backToBack(8, 16'h03, 16'h05, 64'h000F, 16'h20, 16'h22, 64'h0042, "b2b_w8");
    backToBack(4, 16'h3, 16'h5, 64'h0F, 16'h9, 16'h8, 64'h11, "b2b_w4");
    backToBack(16, 16'h0100, 16'h0100, 64'h0001_0000, 16'hFFFF, 16'h0001, 64'h0001_0000, "b2b_w16");

    applyStimulus(4, 2'b10, 16'h5, 16'h8, 64'h13, 1'b0, 1, "w4_bcd_5_8");
    applyStimulus(4, 2'b11, 16'hF, 16'hF, 64'hE1, 1'b0, 4, "w4_mul_f_f");
    applyStimulus(16, 2'b10, 16'h9999, 16'h0001, 64'h0001_0000, 1'b0, 4, "w16_bcd");
    applyStimulus(16, 2'b11, 16'hFFFF, 16'hFFFF, 64'hFFFE_0001, 1'b0, 16, "w16_mul");

    // Reset in the middle of a multiply discards it immediately
    @(negedge clk);
    s = 2'b11; a = 16'hFF; b = 16'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midop_reset_y8", 64'(y8), 64'd0);
    checkOutput("midop_reset_busy8", 64'(busy8), 64'd0);
    checkOutput("midop_reset_done8", 64'(done8), 64'd0);
    checkOutput("midop_reset_err8", 64'(err8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    checkOutput("no_done_after_abort", 64'(ndone), 64'd0);

    // Random traffic on the WIDTH=8 instance, checked by the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start8 = ($urandom_range(0, 2) == 0);
      s = 2'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        a[3:0] = 4'($urandom_range(0, 9));
        a[7:4] = 4'($urandom_range(0, 9));
        b[3:0] = 4'($urandom_range(0, 9));
        b[7:4] = 4'($urandom_range(0, 9));
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    repeat (12) @(negedge clk);
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
